apb_req_arbiter: RTL and testbench

//  Shares the single APB master bridge command port (TRANSFER/READ_WRITE/PWADDR/PRADDR/PWDATA)

---
 rtl/apb_arb_pkg.sv | 19 +
 rtl/apb_req_arbiter_rr_arbiter.sv | 34 +++
 rtl/apb_req_arbiter.sv | 113 +++++++++++
 tb/tb_apb_req_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB requester arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_ADDR_W   = 9;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_XFER_LAT = 3;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/apb_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        // Offsets start at 1 so the last winner has the lowest priority.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand     = (int'(ptr) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!any && req[cand_idx]) begin
                any             = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin sharing of one APB bridge command port; one fixed-latency transaction at a time.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int XFER_LAT = DEF_XFER_LAT
) (
    input  logic                      clk,
    input  logic                      PRESET,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      PRESETn,
    output logic                      TRANSFER,
    output logic                      READ_WRITE,
    output logic [ADDR_W-1:0]         PWADDR,
    output logic [ADDR_W-1:0]         PRADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [DATA_W-1:0]         DATA_OUT,
    input  logic                      PSLVERR
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(XFER_LAT + 1);

    state_e             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               any;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    assign sel_addr  = req_addr[grant_idx*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[grant_idx*DATA_W +: DATA_W];

    // Accept is combinational so the requester sees it in the same IDLE cycle it wins.
    assign req_ready = (state == IDLE && !PRESET) ? grant : '0;

    always_ff @(posedge clk) begin
        PRESETn <= ~PRESET;
        if (PRESET) begin
            state      <= IDLE;
            rr_ptr     <= IDX_W'(NUM_REQ - 1);
            cnt        <= '0;
            TRANSFER   <= 1'b0;
            READ_WRITE <= 1'b0;
            PWADDR     <= '0;
            PRADDR     <= '0;
            PWDATA     <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            TRANSFER  <= 1'b0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    // The bus field registers double as the command registers.
                    if (any) begin
                        rr_ptr     <= grant_idx;
                        TRANSFER   <= 1'b1;
                        READ_WRITE <= req_write[grant_idx] ? RW_WRITE : RW_READ;
                        PWADDR     <= req_write[grant_idx] ? sel_addr : '0;
                        PRADDR     <= req_write[grant_idx] ? '0 : sel_addr;
                        PWDATA     <= req_write[grant_idx] ? sel_wdata : '0;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt   <= CNT_W'(XFER_LAT - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_rdata         <= (READ_WRITE == RW_READ) ? DATA_OUT : '0;
                        rsp_err           <= PSLVERR;
                        rsp_valid[rr_ptr] <= 1'b1;
                        READ_WRITE        <= 1'b0;
                        PWADDR            <= '0;
                        PRADDR            <= '0;
                        PWDATA            <= '0;
                        state             <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_apb_req_arbiter;

    localparam int N   = 4;
    localparam int AW  = 9;
    localparam int DW  = 8;
    localparam int LAT = 3;

    logic            clk;
    logic            PRESET;
    logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, PWDATA, DATA_OUT;
    logic            rsp_err, PRESETn, TRANSFER, READ_WRITE, PSLVERR;
    logic [AW-1:0]   PWADDR, PRADDR;

    apb_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .XFER_LAT(LAT)) dut (
        .clk(clk), .PRESET(PRESET), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PRESETn(PRESETn), .TRANSFER(TRANSFER), .READ_WRITE(READ_WRITE),
        .PWADDR(PWADDR), .PRADDR(PRADDR), .PWDATA(PWDATA),
        .DATA_OUT(DATA_OUT), .PSLVERR(PSLVERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic wr; logic [AW-1:0] addr; logic [DW-1:0] wd; } req_t;
    typedef struct packed { int cyc; logic [N-1:0] oh; } gnt_t;
    typedef struct packed { int cyc; logic rw; logic [AW-1:0] wa; logic [AW-1:0] ra; logic [DW-1:0] wd; } xfer_t;
    typedef struct packed { int cyc; logic [N-1:0] oh; logic [DW-1:0] rd; logic er; } rsp_t;

    req_t  rq [N][$];
    gnt_t  dut_g[$], mdl_g[$];
    xfer_t dut_x[$], mdl_x[$];
    rsp_t  dut_r[$], mdl_r[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [N-1:0]  acc_mask = '0;
    int            br_k = -1;
    bit            br_drive_now = 0;
    bit            br_use_next = 0;
    logic [DW-1:0] br_data, br_next_data;
    logic          br_err, br_next_err;
    int            m_free = 0;
    int            m_last = N - 1;
    int            m_cur_cyc, m_cur_idx;
    logic          m_cur_wr;

    // Environment: requesters, bridge model and transaction-level reference model.
    initial begin : env
        gnt_t g; xfer_t x; rsp_t r; int w; int j;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        DATA_OUT = '0; PSLVERR = 1'b0; br_data = '0; br_err = 1'b0;
        br_next_data = '0; br_next_err = 1'b0; m_cur_cyc = 0; m_cur_idx = 0; m_cur_wr = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int i = 0; i < N; i++)
                if (acc_mask[i] && rq[i].size() > 0) rq[i].delete(0);
            acc_mask = '0;
            for (int i = 0; i < N; i++) begin
                if (rq[i].size() > 0) begin
                    req_valid[i] = 1'b1;
                    req_write[i] = rq[i][0].wr;
                    req_addr[i*AW +: AW] = rq[i][0].addr;
                    req_wdata[i*DW +: DW] = rq[i][0].wd;
                end else begin
                    req_valid[i] = 1'b0;
                    req_write[i] = 1'($urandom);
                    req_addr[i*AW +: AW] = AW'($urandom);
                    req_wdata[i*DW +: DW] = DW'($urandom);
                end
            end
            br_drive_now = 0;
            if (br_k > 0) br_k--;
            if (br_k == 0) begin
                br_data = br_use_next ? br_next_data : DW'($urandom);
                br_err  = br_use_next ? br_next_err : 1'($urandom);
                DATA_OUT = br_data; PSLVERR = br_err;
                br_drive_now = 1; br_k = -1;
            end else begin
                DATA_OUT = ~br_data; PSLVERR = ~br_err;
            end
            @(negedge clk);
            if (PRESET) begin
                m_free = cyc + 1; m_last = N - 1; br_k = -1; acc_mask = '0;
            end else begin
                acc_mask = req_ready;
                if (req_ready != '0) begin g.cyc = cyc; g.oh = req_ready; dut_g.push_back(g); end
                if (TRANSFER) begin
                    x.cyc = cyc; x.rw = READ_WRITE; x.wa = PWADDR; x.ra = PRADDR; x.wd = PWDATA;
                    dut_x.push_back(x); br_k = LAT;
                end
                if (rsp_valid != '0) begin
                    r.cyc = cyc; r.oh = rsp_valid; r.rd = rsp_rdata; r.er = rsp_err; dut_r.push_back(r);
                end
                if (br_drive_now) begin
                    r.cyc = m_cur_cyc + LAT + 2; r.oh = N'(1) << m_cur_idx;
                    r.rd = m_cur_wr ? '0 : br_data; r.er = br_err; mdl_r.push_back(r);
                end
                if (cyc >= m_free && req_valid != '0) begin
                    w = -1;
                    for (int s = 1; s <= N; s++) begin
                        j = (m_last + s) % N;
                        if (w < 0 && req_valid[j]) w = j;
                    end
                    g.cyc = cyc; g.oh = N'(1) << w; mdl_g.push_back(g);
                    x.cyc = cyc + 1; x.rw = ~req_write[w];
                    x.wa = req_write[w] ? req_addr[w*AW +: AW] : '0;
                    x.ra = req_write[w] ? '0 : req_addr[w*AW +: AW];
                    x.wd = req_write[w] ? req_wdata[w*DW +: DW] : '0;
                    mdl_x.push_back(x);
                    m_cur_cyc = cyc; m_cur_idx = w; m_cur_wr = req_write[w];
                    m_last = w; m_free = cyc + LAT + 3;
                end
            end
        end
    end

    task automatic clear_logs();
        dut_g.delete(); mdl_g.delete(); dut_x.delete(); mdl_x.delete(); dut_r.delete(); mdl_r.delete();
    endtask

    task automatic wait_quiet(output bit ok);
        int pend;
        ok = 0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk); #1;
            pend = 0;
            for (int i = 0; i < N; i++) pend += rq[i].size();
            if (pend == 0 && cyc > m_free + 1) begin ok = 1; break; end
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #2 PRESET = 1'b1;
        repeat (n) @(posedge clk);
        #2 PRESET = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({TRANSFER, READ_WRITE, PWADDR, PRADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, req_ready, PRESETn} !== '0) begin
                bad++;
                $display("FAIL reset_outputs cyc%0d got T=%b RW=%b WA=%h RA=%h WD=%h RV=%b RD=%h RE=%b RR=%b PN=%b exp all 0",
                         k, TRANSFER, READ_WRITE, PWADDR, PRADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, req_ready, PRESETn);
            end
        end
        #1 PRESET = 1'b0;
        @(negedge clk);
        total++; if (PRESETn !== 1'b1) begin bad++; $display("FAIL reset_release_presetn got=%b exp=1", PRESETn); end
        total++; if (TRANSFER !== 1'b0 || rsp_valid !== '0 || req_ready !== '0) begin
            bad++; $display("FAIL reset_idle got T=%b RV=%b RR=%b exp 0", TRANSFER, rsp_valid, req_ready);
        end
    endtask

    task automatic test_write();
        bit ok; req_t q;
        clear_logs();
        br_use_next = 1; br_next_data = 8'h77; br_next_err = 1'b0;
        q.wr = 1'b1; q.addr = 9'h1A5; q.wd = 8'h3C; rq[1].push_back(q);
        wait_quiet(ok);
        total++; if (!ok) begin bad++; $display("FAIL wr_timeout got=%0d exp=1", ok); end
        total++; if (dut_g.size() != 1) begin bad++; $display("FAIL wr_grant_count got=%0d exp=1", dut_g.size()); end
        total++; if (dut_x.size() != 1) begin bad++; $display("FAIL wr_xfer_count got=%0d exp=1", dut_x.size()); end
        total++; if (dut_r.size() != 1) begin bad++; $display("FAIL wr_rsp_count got=%0d exp=1", dut_r.size()); end
        if (dut_g.size() > 0 && dut_x.size() > 0 && dut_r.size() > 0) begin
            total++; if (dut_g[0].oh !== 4'b0010) begin bad++; $display("FAIL wr_ready got=%b exp=0010", dut_g[0].oh); end
            total++; if (dut_x[0].cyc != dut_g[0].cyc + 1) begin bad++; $display("FAIL wr_xfer_cycle got=%0d exp=%0d", dut_x[0].cyc, dut_g[0].cyc + 1); end
            total++; if ({dut_x[0].rw, dut_x[0].wa, dut_x[0].ra, dut_x[0].wd} !== {1'b0, 9'h1A5, 9'h000, 8'h3C}) begin
                bad++; $display("FAIL wr_fields got rw=%b wa=%h ra=%h wd=%h exp rw=0 wa=1a5 ra=000 wd=3c",
                                dut_x[0].rw, dut_x[0].wa, dut_x[0].ra, dut_x[0].wd);
            end
            total++; if (dut_r[0].oh !== 4'b0010) begin bad++; $display("FAIL wr_rsp_valid got=%b exp=0010", dut_r[0].oh); end
            total++; if (dut_r[0].cyc != dut_g[0].cyc + LAT + 2) begin bad++; $display("FAIL wr_latency got=%0d exp=%0d", dut_r[0].cyc - dut_g[0].cyc, LAT + 2); end
            total++; if (dut_r[0].er !== 1'b0 || dut_r[0].rd !== 8'h00) begin bad++; $display("FAIL wr_rsp got err=%b rd=%h exp err=0 rd=00", dut_r[0].er, dut_r[0].rd); end
        end
    endtask

    task automatic test_read();
        bit ok; req_t q;
        clear_logs();
        br_use_next = 1; br_next_data = 8'hA5; br_next_err = 1'b0;
        q.wr = 1'b0; q.addr = 9'h010; q.wd = 8'hEE; rq[0].push_back(q);
        wait_quiet(ok);
        total++; if (!ok) begin bad++; $display("FAIL rd_timeout got=%0d exp=1", ok); end
        total++; if (dut_x.size() != 1 || dut_r.size() != 1) begin bad++; $display("FAIL rd_counts got x=%0d r=%0d exp 1 1", dut_x.size(), dut_r.size()); end
        if (dut_x.size() > 0 && dut_r.size() > 0) begin
            total++; if ({dut_x[0].rw, dut_x[0].wa, dut_x[0].ra, dut_x[0].wd} !== {1'b1, 9'h000, 9'h010, 8'h00}) begin
                bad++; $display("FAIL rd_fields got rw=%b wa=%h ra=%h wd=%h exp rw=1 wa=000 ra=010 wd=00",
                                dut_x[0].rw, dut_x[0].wa, dut_x[0].ra, dut_x[0].wd);
            end
            total++; if (dut_r[0].oh !== 4'b0001) begin bad++; $display("FAIL rd_rsp_valid got=%b exp=0001", dut_r[0].oh); end
            total++; if (dut_r[0].rd !== 8'hA5) begin bad++; $display("FAIL rd_rdata got=%h exp=a5", dut_r[0].rd); end
        end
        @(negedge clk);
        total++; if (rsp_rdata !== 8'hA5) begin bad++; $display("FAIL rd_rdata_hold got=%h exp=a5", rsp_rdata); end
    endtask

    task automatic test_rr_order();
        bit ok; req_t q; int exp_o[5] = '{0, 1, 2, 3, 0};
        do_reset(2);
        clear_logs();
        br_use_next = 0;
        for (int i = 0; i < N; i++) begin
            q.wr = 1'($urandom); q.addr = AW'($urandom); q.wd = DW'($urandom); rq[i].push_back(q);
        end
        q.wr = 1'b1; q.addr = 9'h0AA; q.wd = 8'h55; rq[0].push_back(q);
        wait_quiet(ok);
        total++; if (!ok) begin bad++; $display("FAIL rr_timeout got=%0d exp=1", ok); end
        total++; if (dut_g.size() != 5) begin bad++; $display("FAIL rr_grant_count got=%0d exp=5", dut_g.size()); end
        for (int k = 0; k < 5 && k < dut_g.size(); k++) begin
            total++; if (dut_g[k].oh !== N'(1) << exp_o[k]) begin bad++; $display("FAIL rr_order[%0d] got=%b exp=%b", k, dut_g[k].oh, N'(1) << exp_o[k]); end
            if (k > 0) begin
                total++; if (dut_g[k].cyc - dut_g[k-1].cyc != LAT + 3) begin bad++; $display("FAIL rr_spacing[%0d] got=%0d exp=%0d", k, dut_g[k].cyc - dut_g[k-1].cyc, LAT + 3); end
            end
        end
        total++; if (dut_r.size() != 5) begin bad++; $display("FAIL rr_rsp_count got=%0d exp=5", dut_r.size()); end
    endtask

    task automatic test_slverr();
        bit ok; req_t q;
        clear_logs();
        br_use_next = 1; br_next_data = 8'h5A; br_next_err = 1'b1;
        q.wr = 1'b0; q.addr = 9'h0FF; q.wd = 8'h00; rq[3].push_back(q);
        wait_quiet(ok);
        br_next_err = 1'b0;
        q.wr = 1'b1; q.addr = 9'h100; q.wd = 8'h81; rq[3].push_back(q);
        wait_quiet(ok);
        total++; if (!ok) begin bad++; $display("FAIL err_timeout got=%0d exp=1", ok); end
        total++; if (dut_r.size() != 2) begin bad++; $display("FAIL err_rsp_count got=%0d exp=2", dut_r.size()); end
        if (dut_r.size() > 1) begin
            total++; if (dut_r[0].er !== 1'b1 || dut_r[0].rd !== 8'h5A) begin bad++; $display("FAIL err_first got err=%b rd=%h exp err=1 rd=5a", dut_r[0].er, dut_r[0].rd); end
            total++; if (dut_r[1].er !== 1'b0 || dut_r[1].rd !== 8'h00) begin bad++; $display("FAIL err_second got err=%b rd=%h exp err=0 rd=00", dut_r[1].er, dut_r[1].rd); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok; bit seen; req_t q;
        clear_logs();
        br_use_next = 0;
        q.wr = 1'b0; q.addr = 9'h033; q.wd = 8'h00; rq[2].push_back(q);
        seen = 0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk); #1;
            if (dut_x.size() > 0) seen = 1;
        end
        total++; if (!seen) begin bad++; $display("FAIL mid_launch_timeout got=%0d exp=1", seen); end
        @(posedge clk); #2 PRESET = 1'b1;
        @(posedge clk); #2 PRESET = 1'b0;
        @(negedge clk);
        total++; if (TRANSFER !== 1'b0 || rsp_valid !== '0 || PRESETn !== 1'b0) begin
            bad++; $display("FAIL mid_reset_outputs got T=%b RV=%b PN=%b exp 0 0 0", TRANSFER, rsp_valid, PRESETn);
        end
        #1;
        q.wr = 1'b1; q.addr = 9'h044; q.wd = 8'h12; rq[0].push_back(q);
        q.wr = 1'b0; q.addr = 9'h055; q.wd = 8'h00; rq[2].push_back(q);
        wait_quiet(ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_timeout got=%0d exp=1", ok); end
        total++; if (dut_r.size() != 2) begin bad++; $display("FAIL mid_rsp_count got=%0d exp=2", dut_r.size()); end
        if (dut_r.size() > 0) begin
            total++; if (dut_r[0].oh !== 4'b0001) begin bad++; $display("FAIL mid_first_rsp got=%b exp=0001", dut_r[0].oh); end
        end
        total++; if (dut_g.size() != 3) begin bad++; $display("FAIL mid_grant_count got=%0d exp=3", dut_g.size()); end
        if (dut_g.size() > 2) begin
            total++; if (dut_g[1].oh !== 4'b0001 || dut_g[2].oh !== 4'b0100) begin
                bad++; $display("FAIL mid_grant_order got=%b,%b exp=0001,0100", dut_g[1].oh, dut_g[2].oh);
            end
        end
    endtask

    task automatic test_random();
        bit ok; req_t q;
        do_reset(1);
        clear_logs();
        br_use_next = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk); #2;
            for (int i = 0; i < N; i++) begin
                if (rq[i].size() < 2 && $urandom_range(0, 11) == 0) begin
                    q.wr = 1'($urandom); q.addr = AW'($urandom); q.wd = DW'($urandom); rq[i].push_back(q);
                end
            end
        end
        wait_quiet(ok);
        total++; if (!ok) begin bad++; $display("FAIL rnd_timeout got=%0d exp=1", ok); end
        total++; if (dut_g.size() != mdl_g.size()) begin bad++; $display("FAIL rnd_grant_count got=%0d exp=%0d", dut_g.size(), mdl_g.size()); end
        total++; if (dut_x.size() != mdl_x.size()) begin bad++; $display("FAIL rnd_xfer_count got=%0d exp=%0d", dut_x.size(), mdl_x.size()); end
        total++; if (dut_r.size() != mdl_r.size()) begin bad++; $display("FAIL rnd_rsp_count got=%0d exp=%0d", dut_r.size(), mdl_r.size()); end
        for (int k = 0; k < dut_g.size() && k < mdl_g.size(); k++) begin
            total++; if (dut_g[k] !== mdl_g[k]) begin bad++; $display("FAIL rnd_grant[%0d] got cyc=%0d oh=%b exp cyc=%0d oh=%b", k, dut_g[k].cyc, dut_g[k].oh, mdl_g[k].cyc, mdl_g[k].oh); end
        end
        for (int k = 0; k < dut_x.size() && k < mdl_x.size(); k++) begin
            total++; if (dut_x[k] !== mdl_x[k]) begin bad++; $display("FAIL rnd_xfer[%0d] got=%h exp=%h", k, dut_x[k], mdl_x[k]); end
        end
        for (int k = 0; k < dut_r.size() && k < mdl_r.size(); k++) begin
            total++; if (dut_r[k] !== mdl_r[k]) begin bad++; $display("FAIL rnd_rsp[%0d] got cyc=%0d oh=%b rd=%h er=%b exp cyc=%0d oh=%b rd=%h er=%b",
                k, dut_r[k].cyc, dut_r[k].oh, dut_r[k].rd, dut_r[k].er, mdl_r[k].cyc, mdl_r[k].oh, mdl_r[k].rd, mdl_r[k].er); end
        end
    endtask

    initial begin
        PRESET = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_rr_order();
        test_slverr();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
